// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures each ALU result and feeds it byte by byte
// to the UART transmitter through its data/valid handshake, flagging overrun
// when a new result shows up before the previous one has been fully sent.
// OUT_WIDTH must be a non-zero multiple of 8.
module alu_result_serializer #(
  parameter int OUT_WIDTH = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [OUT_WIDTH-1:0] ALU_OUT,
  input  logic                 OUT_VALID,
  input  logic                 TX_BUSY,
  input  logic                 CLR_OVR,
  output logic [7:0]           TX_P_DATA,
  output logic                 TX_D_VLD,
  output logic                 SER_BUSY,
  output logic                 OVERRUN
);

  localparam int NUM_BYTES = OUT_WIDTH / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t               state, state_next;
  logic [OUT_WIDTH-1:0] hold, hold_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [7:0]           data_next;
  logic                 overrun_event;

  // Picks the byte for a given counter value, honouring the configured order.
  function automatic logic [7:0] select_byte(input logic [OUT_WIDTH-1:0] value,
                                             input logic [CNT_W-1:0]     c);
    int                   idx;
    logic [OUT_WIDTH-1:0] shifted;
    idx     = MSB_FIRST ? (NUM_BYTES - 1 - int'(c)) : int'(c);
    shifted = value >> (8 * idx);
    return shifted[7:0];
  endfunction

  // A result arriving anywhere but IDLE (including the cycle we leave
  // WAIT_DONE for IDLE) cannot be stored and is therefore dropped.
  assign overrun_event = OUT_VALID && (state != IDLE);
  assign SER_BUSY      = (state != IDLE);

  // Next-state logic; the outgoing byte is loaded into TX_P_DATA on entry to
  // ISSUE so it is already stable when the single-cycle strobe is raised.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    cnt_next   = cnt;
    data_next  = TX_P_DATA;
    TX_D_VLD   = 1'b0;
    case (state)
      IDLE: begin
        if (OUT_VALID) begin
          hold_next  = ALU_OUT;
          cnt_next   = '0;
          data_next  = select_byte(ALU_OUT, '0);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!TX_BUSY) begin
          TX_D_VLD   = RST;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (TX_BUSY) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (cnt == LAST_CNT) begin
            state_next = IDLE;
          end else begin
            cnt_next   = cnt + CNT_W'(1);
            data_next  = select_byte(hold, cnt + CNT_W'(1));
            state_next = ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, holding register, byte counter, output byte and sticky overrun;
  // a new overrun wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      hold      <= '0;
      cnt       <= '0;
      TX_P_DATA <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      state     <= state_next;
      hold      <= hold_next;
      cnt       <= cnt_next;
      TX_P_DATA <= data_next;
      if (overrun_event) begin
        OVERRUN <= 1'b1;
      end else if (CLR_OVR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

endmodule
